// File: rtl/inst_cache_assoc_if.sv
// Fetch-side and refill-side signals of the instruction cache, grouped into one bundle.
interface inst_cache_assoc_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic [ADDR_WIDTH-1:0]                fetch_addr;
  logic                                 fetch_valid;
  logic                                 flush;
  logic [DATA_WIDTH-1:0]                instr;
  logic                                 instr_valid;
  logic                                 stall;
  logic                                 mem_req;
  logic [ADDR_WIDTH-1:0]                mem_addr;
  logic                                 mem_ack;
  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_rdata;

  // Handshakes: fetch holds fetch_addr/fetch_valid while stall=1. A refill keeps
  // mem_req=1 and mem_addr stable up to and including the mem_ack cycle. mem_ack
  // qualifies mem_rdata and completes the transfer. mem_req drops the cycle after.
  modport master (
    output fetch_addr, fetch_valid, flush, mem_ack, mem_rdata,
    input  instr, instr_valid, stall, mem_req, mem_addr
  );
  modport slave (
    input  fetch_addr, fetch_valid, flush, mem_ack, mem_rdata,
    output instr, instr_valid, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/inst_cache_assoc.sv
// N-way set-associative instruction cache with request/ack refill and set-walking flush.
// Define ICACHE_LRU_EN for true-LRU replacement; otherwise a per-set round-robin pointer is used.
module inst_cache_assoc #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int WAYS           = 2,
  parameter int NUM_SETS       = 32
) (
  input  logic                clk,
  input  logic                rst,
  inst_cache_assoc_if.slave   bus,
  output logic [1:0]          dbg_state_o
);
  localparam int OFF    = $clog2(WORDS_PER_LINE);
  localparam int IDX    = $clog2(NUM_SETS);
  localparam int TAG    = ADDR_WIDTH - IDX - OFF - 2;
  localparam int WW     = $clog2(WAYS);
  localparam int LINE_W = WORDS_PER_LINE * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MISS = 2'd1, S_FLUSH = 2'd2} state_e;
  state_e state_q, state_d;

  logic [LINE_W-1:0]     data_q  [NUM_SETS][WAYS];
  logic [TAG-1:0]        tag_q   [NUM_SETS][WAYS];
  logic [WAYS-1:0]       valid_q [NUM_SETS];
  logic                  mem_req_q, flush_pend_q, victim_old_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [IDX-1:0]        set_cnt_q;
  logic [WW-1:0]         victim_q;

  logic [OFF-1:0] f_off;
  logic [IDX-1:0] f_idx, m_idx;
  logic [TAG-1:0] f_tag, m_tag;
  logic           unused_fetch_lsbs;
  assign f_off = bus.fetch_addr[OFF+1:2];
  assign f_idx = bus.fetch_addr[IDX+OFF+1:OFF+2];
  assign f_tag = bus.fetch_addr[ADDR_WIDTH-1:IDX+OFF+2];
  assign m_idx = mem_addr_q[IDX+OFF+1:OFF+2];
  assign m_tag = mem_addr_q[ADDR_WIDTH-1:IDX+OFF+2];
  assign unused_fetch_lsbs = ^bus.fetch_addr[1:0];

  logic [WAYS-1:0] hit_vec;
  logic            hit, any_inv;
  logic [WW-1:0]   hit_way, inv_way, victim;

  // Descending walk so the lowest-index match / invalid way is the one kept.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag);
      if (hit_vec[w]) hit_way = WW'(w);
      if (!valid_q[f_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end
  assign hit = |hit_vec;

`ifdef ICACHE_LRU_EN
  logic [WAYS-1:0][WW-1:0] age_q [NUM_SETS];
  logic [WW-1:0]           lru_way;

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[f_idx][w] == WW'(WAYS - 1)) lru_way = WW'(w);
  end
  assign victim = any_inv ? inv_way : lru_way;

  function automatic logic [WAYS-1:0][WW-1:0] lru_touch(
      input logic [WAYS-1:0][WW-1:0] ages, input logic [WW-1:0] way,
      input logic [WW-1:0] old_age);
    logic [WAYS-1:0][WW-1:0] res;
    for (int j = 0; j < WAYS; j++) begin
      if (WW'(j) == way)          res[j] = '0;
      else if (ages[j] < old_age) res[j] = ages[j] + 1'b1;
      else                        res[j] = ages[j];
    end
    return res;
  endfunction
`else
  logic [WW-1:0] rr_q [NUM_SETS];
  assign victim = any_inv ? inv_way : rr_q[f_idx];
`endif

  logic [LINE_W-1:0]     hit_line;
  logic [DATA_WIDTH-1:0] hit_word, fill_word, instr_c;
  logic                  valid_c, stall_c, do_hit, do_fill, start_miss;
  assign hit_line  = data_q[f_idx][hit_way];
  assign hit_word  = hit_line[int'(f_off)*DATA_WIDTH +: DATA_WIDTH];
  assign fill_word = bus.mem_rdata[int'(f_off)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d    = state_q;
    instr_c    = '0;
    valid_c    = 1'b0;
    stall_c    = 1'b0;
    do_hit     = 1'b0;
    do_fill    = 1'b0;
    start_miss = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          state_d = S_FLUSH;
          stall_c = bus.fetch_valid;
        end else if (bus.fetch_valid) begin
          if (hit) begin
            instr_c = hit_word;
            valid_c = 1'b1;
            do_hit  = 1'b1;
          end else begin
            stall_c    = 1'b1;
            start_miss = 1'b1;
            state_d    = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (bus.mem_ack) begin
          instr_c = fill_word;
          valid_c = 1'b1;
          do_fill = 1'b1;
          state_d = (flush_pend_q || bus.flush) ? S_FLUSH : S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      S_FLUSH: begin
        stall_c = 1'b1;
        if (set_cnt_q == IDX'(NUM_SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      set_cnt_q    <= '0;
      victim_q     <= '0;
      victim_old_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
`ifdef ICACHE_LRU_EN
        age_q[s] <= '0;
`else
        rr_q[s] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        mem_req_q    <= 1'b1;
        mem_addr_q   <= {bus.fetch_addr[ADDR_WIDTH-1:OFF+2], {(OFF+2){1'b0}}};
        victim_q     <= victim;
        victim_old_q <= ~any_inv;
      end
      if (state_q == S_MISS) begin
        if (bus.mem_ack)    flush_pend_q <= 1'b0;
        else if (bus.flush) flush_pend_q <= 1'b1;
      end
      if (do_fill) begin
        mem_req_q                 <= 1'b0;
        valid_q[m_idx][victim_q] <= 1'b1;
      end
      // Ages are zeroed with the valid bits so refills after a flush rebuild a clean order.
      if (state_q == S_FLUSH) begin
        valid_q[set_cnt_q] <= '0;
        set_cnt_q <= (set_cnt_q == IDX'(NUM_SETS - 1)) ? '0 : set_cnt_q + 1'b1;
`ifdef ICACHE_LRU_EN
        age_q[set_cnt_q] <= '0;
`endif
      end
`ifdef ICACHE_LRU_EN
      // Filling an invalid way counts as touching the oldest entry.
      if (do_hit)
        age_q[f_idx] <= lru_touch(age_q[f_idx], hit_way, age_q[f_idx][hit_way]);
      else if (do_fill)
        age_q[m_idx] <= lru_touch(age_q[m_idx], victim_q,
                                  victim_old_q ? age_q[m_idx][victim_q] : WW'(WAYS - 1));
`else
      if (do_fill && victim_old_q) rr_q[m_idx] <= rr_q[m_idx] + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_q[m_idx][victim_q] <= bus.mem_rdata;
      tag_q[m_idx][victim_q]  <= m_tag;
    end
  end

  assign bus.instr       = instr_c;
  assign bus.instr_valid = valid_c;
  assign bus.stall       = stall_c;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_inst_cache_assoc.sv
// Bench for inst_cache_assoc: directed scenarios plus random traffic against a line-level cache model.
module tb_inst_cache_assoc;
  localparam int DW = 32, AW = 32, WPL = 4, WAYS = 2, NS = 32, LW = WPL * DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  inst_cache_assoc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL)) bus ();

  inst_cache_assoc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL),
                     .WAYS(WAYS), .NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                mv    [NS][WAYS];
  logic [AW-1:0]     mline [NS][WAYS];
  logic [LW-1:0]     mdata [NS][WAYS];
  int unsigned       mlast [NS][WAYS];
  int                mrr   [NS];
  int unsigned       mtime;
  logic [AW-1:0]     exp_q[$];          // outstanding refill line address
  logic [AW-1:0]     m_mem_addr;
  int                m_victim, m_flush_left;
  bit                m_victim_old, m_pend, m_last_stall;

  function automatic int set_of(input logic [AW-1:0] a);
    return int'((a / (WPL * 4)) % NS);
  endfunction
  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a & ~AW'(WPL * 4 - 1);
  endfunction
  function automatic int off_of(input logic [AW-1:0] a);
    return int'((a / 4) % WPL);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; mlast[s][w] = 0; end
    end
    exp_q.delete();
    mtime = 0; m_mem_addr = '0; m_flush_left = 0; m_pend = 0; m_last_stall = 0;
  endfunction

  function automatic void start_flush();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    m_flush_left = NS;
  endfunction

  function automatic int pick_victim(input int s);
    int best;
    for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
`ifdef ICACHE_LRU_EN
    best = 0;
    for (int w = 1; w < WAYS; w++) if (mlast[s][w] < mlast[s][best]) best = w;
    return best;
`else
    best = mrr[s];
    return best;
`endif
  endfunction

  function automatic void install(input logic [AW-1:0] line, input logic [LW-1:0] d);
    int s;
    s = set_of(line);
    mv[s][m_victim] = 1; mline[s][m_victim] = line; mdata[s][m_victim] = d;
    mtime++; mlast[s][m_victim] = mtime;
    if (m_victim_old) mrr[s] = (mrr[s] + 1) % WAYS;
  endfunction

  // ---------------- scoreboard: checks every cycle ----------------
  logic [DW-1:0] e_instr;
  logic [AW-1:0] e_addr;
  bit            e_valid, e_stall, e_req, m_hit;
  int            ms, m_hw;

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      e_instr = '0; e_valid = 0; e_stall = 0;
      e_req = (exp_q.size() != 0);
      e_addr = m_mem_addr;
      if (m_flush_left > 0) begin
        e_stall = 1;
        m_flush_left--;
      end else if (exp_q.size() != 0) begin
        if (bus.mem_ack) begin
          e_instr = bus.mem_rdata[off_of(bus.fetch_addr)*DW +: DW];
          e_valid = 1;
          install(exp_q.pop_front(), bus.mem_rdata);
          if (m_pend || bus.flush) start_flush();
          m_pend = 0;
        end else begin
          e_stall = 1;
          if (bus.flush) m_pend = 1;
        end
      end else if (bus.flush) begin
        e_stall = bus.fetch_valid;
        start_flush();
      end else if (bus.fetch_valid) begin
        ms = set_of(bus.fetch_addr); m_hit = 0; m_hw = 0;
        for (int w = 0; w < WAYS; w++)
          if (mv[ms][w] && mline[ms][w] == line_of(bus.fetch_addr)) begin m_hit = 1; m_hw = w; end
        if (m_hit) begin
          e_instr = mdata[ms][m_hw][off_of(bus.fetch_addr)*DW +: DW];
          e_valid = 1;
          mtime++; mlast[ms][m_hw] = mtime;
        end else begin
          e_stall = 1;
          m_victim = pick_victim(ms);
          m_victim_old = mv[ms][m_victim];
          exp_q.push_back(line_of(bus.fetch_addr));
          m_mem_addr = line_of(bus.fetch_addr);
        end
      end
      chk("sb_instr", AW'(bus.instr), AW'(e_instr));
      chk("sb_instr_valid", AW'(bus.instr_valid), AW'(e_valid));
      chk("sb_stall", AW'(bus.stall), AW'(e_stall));
      chk("sb_mem_req", AW'(bus.mem_req), AW'(e_req));
      chk("sb_mem_addr", bus.mem_addr, e_addr);
      m_last_stall = e_stall;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_valid = 0; bus.flush = 0; bus.mem_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic fill(input logic [AW-1:0] a, input logic [LW-1:0] line, input string nm);
    bus.fetch_addr = a; bus.fetch_valid = 1;
    @(negedge clk); chk({nm, "_miss_stall"}, AW'(bus.stall), 32'h1);
    tick();
    bus.mem_ack = 1; bus.mem_rdata = line;
    @(negedge clk); chk({nm, "_fill_valid"}, AW'(bus.instr_valid), 32'h1);
    tick();
    bus.mem_ack = 0; bus.fetch_valid = 0;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  logic [LW-1:0] l1, l2, l3, rline;
  int            n;
  bit            exp_conf_hit;
  logic [AW-1:0] ra;

  initial begin
    bus.fetch_addr = '0; bus.mem_rdata = '0; idle_inputs();
    l1 = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    l2 = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    l3 = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
    tick(); tick();
    rst = 0;

    // reset state
    @(negedge clk);
    chk("rst_instr", AW'(bus.instr), 32'h0);
    chk("rst_instr_valid", AW'(bus.instr_valid), 32'h0);
    chk("rst_stall", AW'(bus.stall), 32'h0);
    chk("rst_mem_req", AW'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    tick();

    // cold miss, ack in cycle 3
    do_reset();
    bus.fetch_addr = 32'h1000; bus.fetch_valid = 1;
    @(negedge clk); chk("cold_c0_stall", AW'(bus.stall), 32'h1); chk("cold_c0_req", AW'(bus.mem_req), 32'h0);
    tick(); @(negedge clk); chk("cold_c1_req", AW'(bus.mem_req), 32'h1); chk("cold_c1_addr", bus.mem_addr, 32'h1000);
    tick(); @(negedge clk); chk("cold_c2_addr", bus.mem_addr, 32'h1000);
    tick(); bus.mem_ack = 1; bus.mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
    @(negedge clk);
    chk("cold_c3_addr", bus.mem_addr, 32'h1000);
    chk("cold_c3_instr", AW'(bus.instr), 32'h11);
    chk("cold_c3_valid", AW'(bus.instr_valid), 32'h1);
    chk("cold_c3_stall", AW'(bus.stall), 32'h0);
    tick(); bus.mem_ack = 0; bus.fetch_addr = 32'h1004;
    @(negedge clk);
    chk("cold_hit_instr", AW'(bus.instr), 32'h22);
    chk("cold_hit_valid", AW'(bus.instr_valid), 32'h1);
    chk("cold_hit_req", AW'(bus.mem_req), 32'h0);
    tick(); bus.fetch_valid = 0;

    // mid-line miss
    do_reset();
    bus.fetch_addr = 32'h2008; bus.fetch_valid = 1;
    tick(); bus.mem_ack = 1; bus.mem_rdata = l2;
    @(negedge clk);
    chk("mid_addr", bus.mem_addr, 32'h2000);
    chk("mid_instr", AW'(bus.instr), 32'hB3);
    tick(); idle_inputs();

    // conflict in set 0
    do_reset();
    fill(32'h1000, l1, "conf_a");
    fill(32'h1200, l2, "conf_b");
    bus.fetch_addr = 32'h1000; bus.fetch_valid = 1;
    @(negedge clk); chk("conf_hit_a", AW'(bus.instr), 32'hA1);
    tick();
    fill(32'h1400, l3, "conf_c");
`ifdef ICACHE_LRU_EN
    exp_conf_hit = 1;
`else
    exp_conf_hit = 0;
`endif
    bus.fetch_addr = 32'h1000; bus.fetch_valid = 1;
    @(negedge clk); chk("conf_a_again", AW'(bus.instr_valid), AW'(exp_conf_hit));
    tick();
    if (!exp_conf_hit) begin
      bus.mem_ack = 1; bus.mem_rdata = l1;
      tick();
    end
    idle_inputs();

    // flush after fill
    do_reset();
    fill(32'h1000, l1, "fl");
    bus.flush = 1;
    @(negedge clk); chk("fl_pulse_stall", AW'(bus.stall), 32'h0);
    tick(); bus.flush = 0;
    count_stall(n); chk("fl_len", AW'(n), 32'd32);
    tick(); bus.fetch_addr = 32'h1000; bus.fetch_valid = 1;
    @(negedge clk); chk("fl_post_stall", AW'(bus.stall), 32'h1);
    tick(); @(negedge clk); chk("fl_post_req", AW'(bus.mem_req), 32'h1);
    tick(); bus.mem_ack = 1; bus.mem_rdata = l1;
    tick(); idle_inputs();

    // flush during refill
    do_reset();
    bus.fetch_addr = 32'h1000; bus.fetch_valid = 1;
    tick(); bus.flush = 1;
    @(negedge clk); chk("fr_req", AW'(bus.mem_req), 32'h1);
    tick(); bus.flush = 0; bus.mem_ack = 1; bus.mem_rdata = l1;
    @(negedge clk); chk("fr_instr", AW'(bus.instr), 32'hA1); chk("fr_stall", AW'(bus.stall), 32'h0);
    tick(); idle_inputs();
    count_stall(n); chk("fr_len", AW'(n), 32'd32);
    tick(); bus.fetch_addr = 32'h1000; bus.fetch_valid = 1;
    @(negedge clk); chk("fr_post_stall", AW'(bus.stall), 32'h1);
    tick(); @(negedge clk); chk("fr_post_req", AW'(bus.mem_req), 32'h1);
    tick(); bus.mem_ack = 1;
    tick(); idle_inputs();

    // reset mid-miss
    do_reset();
    bus.fetch_addr = 32'h3000; bus.fetch_valid = 1;
    tick(); @(negedge clk); chk("rm_req", AW'(bus.mem_req), 32'h1);
    tick(); rst = 1; bus.fetch_valid = 0;
    tick(); rst = 0; bus.mem_ack = 1; bus.mem_rdata = l3;
    @(negedge clk); chk("rm_req_drop", AW'(bus.mem_req), 32'h0); chk("rm_ack_ignored", AW'(bus.instr_valid), 32'h0);
    tick(); bus.mem_ack = 0; bus.fetch_addr = 32'h3000; bus.fetch_valid = 1;
    @(negedge clk); chk("rm_refetch_miss", AW'(bus.stall), 32'h1);
    tick(); bus.mem_ack = 1;
    tick(); idle_inputs();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!m_last_stall) begin
        ra = (AW'($urandom_range(0, 4)) << 9) | (AW'($urandom_range(0, 3)) << 4) |
             (AW'($urandom_range(0, 3)) << 2);
        bus.fetch_addr = ra;
        bus.fetch_valid = ($urandom_range(0, 3) != 0);
      end
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.mem_ack = ($urandom_range(0, 2) == 0);
      rline = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_rdata = rline;
      tick();
    end
    rst = 0; idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
